// File: rtl/spi_readback_tx.sv
// SPI-slave readback transmitter: decodes a 16-bit read frame and shifts the
// addressed 8-bit register out on miso, oversampling the SPI pins in ck_1356meg.
module spi_readback_tx #(
  parameter logic [3:0] CMD_READ    = 4'b1000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       spck,
  input  logic       ncs,
  input  logic       mosi,
  input  logic [7:0] conf_word,
  input  logic [7:0] divisor,
  input  logic [7:0] conf_enio,
  input  logic [7:0] status,
  output logic       miso,
  output logic       busy,
  output logic       rd_done,
  output logic       status_rd,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, WAIT} state_t;

  logic [SYNC_STAGES-1:0] spck_sync, ncs_sync, mosi_sync;
  logic                   spck_q, ncs_q;
  logic                   spck_s, ncs_s, mosi_s;
  logic                   spck_rise, spck_fall, ncs_rise, ncs_fall;

  state_t     state;
  logic [4:0] bit_cnt;
  logic [7:0] header;
  logic [7:0] shreg;
  logic       cmd_match;
  logic       addr_status;

  logic [7:0] hdr_next;
  logic [7:0] src_sel;
  logic       cmd_hit;
  logic [7:0] load_byte;

  // Synchronizers idle as spck low, ncs deasserted, mosi low.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      spck_sync <= '0;
      ncs_sync  <= '1;
      mosi_sync <= '0;
      spck_q    <= 1'b0;
      ncs_q     <= 1'b1;
    end else begin
      spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      spck_q    <= spck_sync[SYNC_STAGES-1];
      ncs_q     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign spck_s    = spck_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign spck_rise = spck_s & ~spck_q;
  assign spck_fall = ~spck_s & spck_q;
  assign ncs_rise  = ncs_s & ~ncs_q;
  assign ncs_fall  = ~ncs_s & ncs_q;

  always_comb begin
    hdr_next = {header[6:0], mosi_s};
    cmd_hit  = (hdr_next[7:4] == CMD_READ);
    case (hdr_next[1:0])
      2'd0:    src_sel = conf_word;
      2'd1:    src_sel = divisor;
      2'd2:    src_sel = conf_enio;
      default: src_sel = status;
    endcase
    load_byte = cmd_hit ? src_sel : 8'h00;
  end

  // Bit 7 is already on miso when the 8th fall arrives, so the shift is
  // skipped for that fall and the ARM samples bits 7..0 on rises 9..16.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      header      <= '0;
      shreg       <= '0;
      cmd_match   <= 1'b0;
      addr_status <= 1'b0;
      miso        <= 1'b0;
      busy        <= 1'b0;
      rd_done     <= 1'b0;
      status_rd   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rd_done   <= 1'b0;
      status_rd <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            state     <= HDR;
            bit_cnt   <= '0;
            header    <= '0;
            shreg     <= '0;
            cmd_match <= 1'b0;
            busy      <= 1'b1;
            miso      <= 1'b0;
          end
        end
        HDR: begin
          if (ncs_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            miso      <= 1'b0;
            busy      <= 1'b0;
            cmd_match <= 1'b0;
          end else if (spck_rise) begin
            header  <= hdr_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              cmd_match   <= cmd_hit;
              addr_status <= (hdr_next[1:0] == 2'd3);
              shreg       <= load_byte;
              miso        <= load_byte[7];
              state       <= DATA;
            end
          end
        end
        DATA: begin
          if (ncs_rise) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            miso      <= 1'b0;
            busy      <= 1'b0;
            cmd_match <= 1'b0;
          end else if (spck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) state <= WAIT;
          end else if (spck_fall && bit_cnt != 5'd8) begin
            shreg <= {shreg[6:0], 1'b0};
            miso  <= shreg[6];
          end
        end
        WAIT: begin
          if (ncs_rise) begin
            state     <= IDLE;
            rd_done   <= cmd_match;
            status_rd <= cmd_match & addr_status;
            miso      <= 1'b0;
            busy      <= 1'b0;
            cmd_match <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_readback_tx.sv
// Directed self-checking bench for spi_readback_tx: drives SPI mode-0 frames
// at roughly 1 MHz and checks received bytes, pulse timing and abort/reset paths.
`timescale 1ns/1ps
module tb_spi_readback_tx;

  logic       ck_1356meg = 1'b0;
  logic       reset;
  logic       spck, ncs, mosi;
  logic [7:0] conf_word, divisor, conf_enio, status;
  logic       miso, busy, rd_done, status_rd, frame_err;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] rx;
  logic       misoAny;
  logic [3:0] rdVec, stVec, feVec;

  spi_readback_tx #(.CMD_READ(4'b1000), .SYNC_STAGES(2)) dut (
    .ck_1356meg(ck_1356meg),
    .reset     (reset),
    .spck      (spck),
    .ncs       (ncs),
    .mosi      (mosi),
    .conf_word (conf_word),
    .divisor   (divisor),
    .conf_enio (conf_enio),
    .status    (status),
    .miso      (miso),
    .busy      (busy),
    .rd_done   (rd_done),
    .status_rd (status_rd),
    .frame_err (frame_err)
  );

  // 74 ns period, close to 13.56 MHz
  always #37 ck_1356meg = ~ck_1356meg;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives ncs low and nbits mode-0 bits of word (7 clocks per half period);
  // samples miso at each rise and leaves ncs low.
  task automatic applyStimulus(input logic [15:0] word, input int nbits, input bit mutate,
                               output logic [7:0] rxByte, output logic anyHigh);
    rxByte  = 8'h00;
    anyHigh = 1'b0;
    ncs = 1'b0;
    repeat (7) @(negedge ck_1356meg);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      repeat (7) @(negedge ck_1356meg);
      spck = 1'b1;
      anyHigh = anyHigh | miso;
      if (i >= 8) rxByte[15-i] = miso;
      repeat (7) @(negedge ck_1356meg);
      spck = 1'b0;
      if (mutate && i == 7) divisor = 8'h00;
    end
  endtask

  // Raises ncs and records rd_done/status_rd/frame_err over the next 4 cycles.
  task automatic endFrame(output logic [3:0] rdV, output logic [3:0] stV,
                          output logic [3:0] feV);
    repeat (7) @(negedge ck_1356meg);
    ncs  = 1'b1;
    mosi = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ck_1356meg);
      rdV[k] = rd_done;
      stV[k] = status_rd;
      feV[k] = frame_err;
    end
    repeat (6) @(negedge ck_1356meg);
  endtask

  initial begin
    reset = 1'b1;
    spck = 1'b0; ncs = 1'b1; mosi = 1'b0;
    conf_word = 8'h00; divisor = 8'h00; conf_enio = 8'h00; status = 8'h00;
    repeat (3) @(negedge ck_1356meg);
    checkOutput("reset_outputs", {11'd0, miso, busy, rd_done, status_rd, frame_err}, 16'h0000);
    reset = 1'b0;
    repeat (4) @(negedge ck_1356meg);

    $display("[TB] read conf_word");
    conf_word = 8'hA5;
    applyStimulus(16'h8000, 16, 1'b0, rx, misoAny);
    checkOutput("t1_busy_mid", {15'd0, busy}, 16'h0001);
    endFrame(rdVec, stVec, feVec);
    checkOutput("t1_rx", {8'd0, rx}, 16'h00A5);
    checkOutput("t1_rd_done", {12'd0, rdVec}, 16'h0004);
    checkOutput("t1_status_rd", {12'd0, stVec}, 16'h0000);
    checkOutput("t1_frame_err", {12'd0, feVec}, 16'h0000);
    checkOutput("t1_idle_out", {14'd0, miso, busy}, 16'h0000);

    $display("[TB] read status");
    status = 8'h3C;
    applyStimulus(16'h8300, 16, 1'b0, rx, misoAny);
    endFrame(rdVec, stVec, feVec);
    checkOutput("t2_rx", {8'd0, rx}, 16'h003C);
    checkOutput("t2_rd_done", {12'd0, rdVec}, 16'h0004);
    checkOutput("t2_status_rd", {12'd0, stVec}, 16'h0004);

    $display("[TB] write frame passes silently");
    applyStimulus(16'h1042, 16, 1'b0, rx, misoAny);
    checkOutput("t3_busy_mid", {15'd0, busy}, 16'h0001);
    endFrame(rdVec, stVec, feVec);
    checkOutput("t3_miso_any", {15'd0, misoAny}, 16'h0000);
    checkOutput("t3_pulses", {4'd0, rdVec, stVec, feVec}, 16'h0000);
    checkOutput("t3_busy_after", {15'd0, busy}, 16'h0000);

    $display("[TB] divisor snapshot");
    divisor = 8'h5F;
    applyStimulus(16'h8100, 16, 1'b1, rx, misoAny);
    endFrame(rdVec, stVec, feVec);
    checkOutput("t4_rx", {8'd0, rx}, 16'h005F);
    checkOutput("t4_rd_done", {12'd0, rdVec}, 16'h0004);

    $display("[TB] abort after 11 rises");
    conf_enio = 8'h81;
    applyStimulus(16'h8200, 11, 1'b0, rx, misoAny);
    endFrame(rdVec, stVec, feVec);
    checkOutput("t5_frame_err", {12'd0, feVec}, 16'h0004);
    checkOutput("t5_no_rd_done", {8'd0, rdVec, stVec}, 16'h0000);
    checkOutput("t5_idle_out", {14'd0, miso, busy}, 16'h0000);
    applyStimulus(16'h8200, 16, 1'b0, rx, misoAny);
    endFrame(rdVec, stVec, feVec);
    checkOutput("t5_rx", {8'd0, rx}, 16'h0081);
    checkOutput("t5_rd_done", {12'd0, rdVec}, 16'h0004);

    $display("[TB] reset mid-frame");
    applyStimulus(16'h8000, 12, 1'b0, rx, misoAny);
    checkOutput("t6_busy_pre", {15'd0, busy}, 16'h0001);
    reset = 1'b1;
    #1;
    checkOutput("t6_reset_out", {11'd0, miso, busy, rd_done, status_rd, frame_err}, 16'h0000);
    ncs = 1'b1; mosi = 1'b0;
    repeat (4) @(negedge ck_1356meg);
    reset = 1'b0;
    repeat (4) @(negedge ck_1356meg);
    checkOutput("t6_idle_after", {14'd0, busy, frame_err}, 16'h0000);
    applyStimulus(16'h8000, 16, 1'b0, rx, misoAny);
    endFrame(rdVec, stVec, feVec);
    checkOutput("t6_rx", {8'd0, rx}, 16'h00A5);
    checkOutput("t6_rd_done", {12'd0, rdVec}, 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_readback_tx.md
Name: spi_readback_tx

Overview:
- SPI-slave transmitter that drives miso so the ARM can read FPGA state back over the same spck/ncs/mosi bus that loads the configuration registers.
- Runs in the ck_1356meg domain and oversamples the SPI pins.
- Decodes a 16-bit read frame: command nibble, then register address.
- Shifts the selected 8-bit register out MSB-first during the last 8 bits of the frame.
- Instantiated in the top level beside the configuration-register receiver; its miso output goes directly to the miso pin.

Parameters:
- CMD_READ, 4'b1000, command nibble (frame bits 15:12) that selects a readback frame.
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on spck, ncs and mosi (minimum 2).

Ports:
- ck_1356meg  input  1  sole clock, 13.56 MHz.
- reset  input  1  asynchronous, active-high reset.
- spck  input  1  SPI clock from the ARM, asynchronous to ck_1356meg; SPI mode 0.
- ncs  input  1  SPI chip select, active low, asynchronous.
- mosi  input  1  SPI data from the ARM, asynchronous.
- conf_word  input  8  readback source, address 0.
- divisor  input  8  readback source, address 1.
- conf_enio  input  8  readback source, address 2.
- status  input  8  mode-specific status byte, address 3.
- miso  output  1  SPI data to the ARM.
- busy  output  1  high from frame start until ncs returns high.
- rd_done  output  1  one-cycle pulse on successful completion of a read frame.
- status_rd  output  1  one-cycle pulse when an address-3 read completes; mode logic uses it for clear-on-read.
- frame_err  output  1  one-cycle pulse when ncs rises mid-frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; bit counter 0; shift register 0; synchronizers are loaded with spck=0, ncs=1, mosi=0.
- Synchronization and edges: spck, ncs and mosi each pass through SYNC_STAGES flip-flops. Rise and fall of spck and ncs are detected from the last two synchronized samples.
- Timing requirement: each spck high and low phase lasts at least 3 ck_1356meg periods (spck ≤ 2 MHz).
- States: IDLE, HDR, DATA, WAIT.
- IDLE -> HDR on ncs fall. Bit counter cleared, busy=1, miso=0.
- HDR: on each spck rise, shift the synchronized mosi into the 8-bit header and increment the counter.
- HDR, 8th rise: the header is complete (bits 15:8).
  - If header[7:4]==CMD_READ and header[1:0] selects a source, latch that source into the shift register in the same cycle and drive miso = bit 7 of the latched byte on the next cycle.
  - Address decode: header[1:0] 0=conf_word, 1=divisor, 2=conf_enio, 3=status. header[3:2] is ignored.
  - If the command does not match, load 8'h00. The frame continues silently: no rd_done, no status_rd.
  - Go to DATA.
- DATA: on each spck fall, shift left and present the next bit on miso. On each spck rise, increment the counter. mosi is ignored.
- DATA, 16th rise: go to WAIT. miso holds the last bit (bit 0).
- WAIT -> IDLE on ncs rise. If the command matched: rd_done=1 for one cycle, and status_rd=1 as well if the address was 3. Then miso=0, busy=0.
- Spurious spck edges in WAIT are ignored.
- Abort: ncs rise in HDR or DATA -> IDLE. frame_err=1 for one cycle, miso=0, busy=0, no rd_done, no status_rd.
- ncs fall in WAIT without an intervening rise cannot occur; ncs rise always has priority over an spck edge in the same cycle.
- The source value is snapshotted only at the 8th rise. Later changes to conf_word, divisor, conf_enio or status do not affect the frame in progress.
- Latency: ncs rise to rd_done is SYNC_STAGES+1 cycles.
- Write frames (commands 0001/0010/0100) pass through this block silently. It outputs miso=0 and pulses neither rd_done nor status_rd, so writes proceed unaffected.
- Reset asserted mid-frame forces the reset values immediately. After release the block waits for a fresh ncs fall.

Test Plan:
- Reset, then conf_word=8'hA5. Frame 16'h8000 at spck 1 MHz -> miso bits 7..0 = 1,0,1,0,0,1,0,1; rd_done 1-cycle pulse after ncs rise; status_rd=0; frame_err=0.
- status=8'h3C, frame 16'h8300 -> miso returns 0x3C; rd_done and status_rd pulse in the same cycle.
- Frame 16'h1042 (write conf_word) -> miso=0 for all 16 bits; no rd_done, no status_rd, no frame_err; busy high only while ncs is low.
- divisor=8'h5F latched, then divisor changes to 8'h00 after the 8th spck rise, frame 16'h8100 -> ARM reads 0x5F.
- ncs raised after 11 spck rises of frame 16'h8200 -> frame_err pulses once, miso=0, busy=0, no rd_done. The next full frame 16'h8200 with conf_enio=8'h81 returns 0x81.
- reset asserted after 12 bits of a read frame -> all outputs 0 within the same cycle. The following full frame 16'h8000 returns conf_word correctly.
